dog_stage: RTL and testbench
============================

# dog_stage

Difference-of-Gaussians stage that sits directly downstream of two Gaussian blur instances at adjacent scales. It consumes their 8-bit blurred pixel streams and realigns them through a small skew FIFO, because the coarser blur has longer pipeline latency. It emits a signed per-pixel difference with raster position and frame markers, ready for the extrema detector.

## Interface
- IMG_W, 400, pixels per line
- IMG_H, 300, lines per frame
- FIFO_DEPTH, 16, fine-stream skew buffer depth (power of two)
- LOW_TH, 2, contrast threshold; |diff| <= LOW_TH flags low contrast
- Clk  input  1  single clock; all logic on rising edge
- Reset  input  1  asynchronous, active-high; clears all state
- Clk_en  input  1  global stall; when low nothing is accepted and outputs hold
- fine_in  input  8  blurred pixel from the lower-sigma Gaussian
- fine_valid  input  1  fine_in valid this cycle
- coarse_in  input  8  blurred pixel from the higher-sigma Gaussian
- coarse_valid  input  1  coarse_in valid this cycle
- dout  output  9  signed two's-complement fine − coarse
- dout_valid  output  1  dout valid, single-cycle strobe
- col  output  $clog2(IMG_W)  column of current dout
- row  output  $clog2(IMG_H)  row of current dout
- frame_end  output  1  high with dout_valid on pixel (IMG_W−1, IMG_H−1)
- low_contrast  output  1  |dout| <= LOW_TH, qualified by dout_valid
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current skew FIFO occupancy
- ovf_err  output  1  sticky; fine sample arrived with FIFO full
- unf_err  output  1  sticky; coarse sample arrived with no fine sample available

## Operation
- Fine samples are pushed into the skew FIFO when Clk_en & fine_valid.
- A coarse sample (Clk_en & coarse_valid) pops the oldest fine sample and forms one output pair.
- Bypass: if the FIFO is empty and both valids arrive in the same cycle, fine_in pairs directly with coarse_in. No push occurs and fifo_level stays 0.
- Simultaneous push and pop with a non-empty FIFO:
  - The pop is served from the head and the push goes to the tail.
  - Level is unchanged.
  - This is legal even when the FIFO is full; ovf_err is not set in that case.
- Push with the FIFO full and no pop in the same cycle: the sample is dropped, ovf_err is set, and level is unchanged.
- Coarse sample with the FIFO empty and no same-cycle fine sample: the coarse sample is dropped, unf_err is set, and no output is produced.
- Arithmetic: both operands are zero-extended to 9 bits; dout = fine − coarse, giving a range of −255..+255 with no saturation.
- low_contrast compares the absolute value of the 9-bit result with LOW_TH.
- Raster counters:
  - col advances on each dout_valid and wraps from IMG_W−1 to 0, incrementing row.
  - row wraps from IMG_H−1 to 0.
  - col/row on the output are the position of the pixel being presented.
- Error flags clear only on Reset.
- Clk_en low:
  - FIFO, counters and pointers freeze.
  - dout_valid and frame_end are forced low.
  - dout, col, row and low_contrast hold their last values.

## Timing
- Reset values: dout=0, dout_valid=0, col=0, row=0, frame_end=0, low_contrast=0, fifo_level=0, ovf_err=0, unf_err=0; FIFO pointers are 0.
- Latency is 1 cycle from the accepting coarse edge to dout_valid. dout, col, row, frame_end and low_contrast are registered together with dout_valid.
- fifo_level is registered and reflects occupancy after the edge.
- ovf_err and unf_err assert on the edge following the offending cycle.
- Sustained throughput is one output per cycle with no bubbles when the coarse stream trails the fine stream by at most FIFO_DEPTH samples.
- Reset asserted mid-frame:
  - All state clears immediately (asynchronous); the next frame starts at (0,0).
  - In-flight FIFO contents are discarded.
  - Reset deassertion is synchronized externally by the system.

## Test plan
- Fine stream leads coarse by 5 cycles; fine=200, coarse=50 → after 5 pushes, fifo_level=5. Each output has dout=+150, low_contrast=0, and arrives 1 cycle after its coarse_valid. No errors.
- Same-cycle valids with an empty FIFO; fine=10, coarse=12 → bypass path, dout=−2 (9'h1FE), low_contrast=1 (LOW_TH=2), fifo_level stays 0.
- Fill the FIFO with 16 fine samples, then push and pop together, then push alone → the simultaneous push/pop keeps level 16 with ovf_err=0. The lone push sets ovf_err=1 and the sample is dropped.
- A coarse_valid with an empty FIFO and no fine sample → no dout_valid, unf_err=1 (sticky) until Reset.
- Full frame at IMG_W=4, IMG_H=3 with 12 pairs → col cycles 0..3 and row 0..2. frame_end is high only on the 12th output, with col=3, row=2. The 13th output is at (0,0).
- Assert Reset after 6 outputs with 3 samples queued, then release → all outputs and fifo_level read 0, and the next pair emits at (0,0). Separately, hold Clk_en low for 4 cycles mid-stream → no outputs, and the level and counters are unchanged.

Source files
------------

// File: rtl/dog_stage.sv
// dog_stage: Difference-of-Gaussians stage.
// Realigns a fine (lower-sigma) and a coarse (higher-sigma) blurred pixel stream through a
// small skew FIFO on the fine side, then emits the signed difference fine - coarse with its
// raster position, frame-end marker and a low-contrast flag.
//
// Ports:
//   Clk, Reset           clock; asynchronous active-high reset
//   Clk_en               global stall; low freezes all state and suppresses strobes
//   fine_in/fine_valid   fine blurred pixel stream (pushed into the skew FIFO)
//   coarse_in/valid      coarse blurred pixel stream (pops the FIFO, forms a pair)
//   dout, dout_valid     9-bit two's-complement difference and its strobe
//   col, row             raster position of the presented pixel
//   frame_end            strobe on the last pixel of the frame
//   low_contrast         |dout| <= LOW_TH
//   fifo_level           skew FIFO occupancy after the edge
//   ovf_err, unf_err     sticky overflow / underflow flags
module dog_stage #(
    parameter int unsigned IMG_W      = 400,
    parameter int unsigned IMG_H      = 300,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LOW_TH     = 2
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          Clk_en,
    input  logic [7:0]                    fine_in,
    input  logic                          fine_valid,
    input  logic [7:0]                    coarse_in,
    input  logic                          coarse_valid,
    output logic [8:0]                    dout,
    output logic                          dout_valid,
    output logic [$clog2(IMG_W)-1:0]      col,
    output logic [$clog2(IMG_H)-1:0]      row,
    output logic                          frame_end,
    output logic                          low_contrast,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf_err,
    output logic                          unf_err
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [8:0]    LOW_LIM  = 9'(LOW_TH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;

    logic          fifo_empty;
    logic          fifo_full;
    logic          push_req;
    logic          pop_req;
    logic          bypass;
    logic          do_push;
    logic          do_pop;
    logic          ovf_hit;
    logic          unf_hit;
    logic          pair_valid;
    logic [7:0]    fine_op;
    logic [8:0]    diff;
    logic [8:0]    diff_abs;
    logic          last_col;
    logic          last_row;
    logic [LW-1:0] level_next;

    always_comb begin
        fifo_empty = (fifo_level == '0);
        fifo_full  = (fifo_level == LVL_FULL);
        push_req   = Clk_en & fine_valid;
        pop_req    = Clk_en & coarse_valid;
        // Empty FIFO with both samples present: pair directly, nothing is queued.
        bypass     = push_req & pop_req & fifo_empty;
        do_pop     = pop_req & ~fifo_empty;
        // A same-cycle pop frees the head slot, so a push into a full FIFO is still legal.
        do_push    = push_req & ~bypass & (~fifo_full | do_pop);
        ovf_hit    = push_req & fifo_full & ~pop_req;
        unf_hit    = pop_req & fifo_empty & ~push_req;
        pair_valid = bypass | do_pop;
        fine_op    = bypass ? fine_in : mem[rd_ptr];
        diff       = {1'b0, fine_op} - {1'b0, coarse_in};
        diff_abs   = diff[8] ? (~diff + 9'd1) : diff;
        last_col   = (col_cnt == COL_LAST);
        last_row   = (row_cnt == ROW_LAST);
        level_next = fifo_level;
        unique case ({do_push, do_pop})
            2'b10:   level_next = fifo_level + 1'b1;
            2'b01:   level_next = fifo_level - 1'b1;
            default: level_next = fifo_level;
        endcase
    end

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_ptr] <= fine_in;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            ovf_err      <= 1'b0;
            unf_err      <= 1'b0;
            col_cnt      <= '0;
            row_cnt      <= '0;
            dout         <= '0;
            dout_valid   <= 1'b0;
            col          <= '0;
            row          <= '0;
            frame_end    <= 1'b0;
            low_contrast <= 1'b0;
        end else begin
            fifo_level <= level_next;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (ovf_hit) ovf_err <= 1'b1;
            if (unf_hit) unf_err <= 1'b1;

            if (Clk_en) begin
                dout_valid <= pair_valid;
                frame_end  <= pair_valid & last_col & last_row;
                if (pair_valid) begin
                    dout         <= diff;
                    low_contrast <= (diff_abs <= LOW_LIM);
                    col          <= col_cnt;
                    row          <= row_cnt;
                    // col_cnt/row_cnt hold the position of the next pixel to be emitted.
                    if (last_col) begin
                        col_cnt <= '0;
                        row_cnt <= last_row ? '0 : row_cnt + 1'b1;
                    end else begin
                        col_cnt <= col_cnt + 1'b1;
                    end
                end
            end else begin
                dout_valid <= 1'b0;
                frame_end  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dog_stage.sv
// Self-checking bench for dog_stage with a small 4x3 frame.
module tb_dog_stage;

    localparam int unsigned IMG_W = 4;
    localparam int unsigned IMG_H = 3;
    localparam int unsigned FD    = 16;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Clk_en = 1'b1;
    logic [7:0] fine_in = '0;
    logic       fine_valid = 1'b0;
    logic [7:0] coarse_in = '0;
    logic       coarse_valid = 1'b0;
    logic [8:0] dout;
    logic       dout_valid;
    logic [1:0] col;
    logic [1:0] row;
    logic       frame_end;
    logic       low_contrast;
    logic [4:0] fifo_level;
    logic       ovf_err;
    logic       unf_err;

    dog_stage #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(FD), .LOW_TH(2)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Clk_en(Clk_en),
        .fine_in(fine_in), .fine_valid(fine_valid),
        .coarse_in(coarse_in), .coarse_valid(coarse_valid),
        .dout(dout), .dout_valid(dout_valid), .col(col), .row(row),
        .frame_end(frame_end), .low_contrast(low_contrast),
        .fifo_level(fifo_level), .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [8:0] dout;
        logic       low;
        logic [1:0] col;
        logic [1:0] row;
        logic       fe;
    } exp_t;

    typedef struct {
        logic       fv;
        logic [7:0] f;
        logic       cv;
        logic [7:0] c;
        int         exp_level;
        logic       exp_valid;
        logic [8:0] exp_dout;
        logic       exp_low;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    exp_t       sb[$];
    logic [7:0] m_fifo[$];
    int         m_col = 0;
    int         m_row = 0;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    exp_t       last_exp = '0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic make_pair(input logic [7:0] f, input logic [7:0] c);
        exp_t e;
        int   d;
        d      = int'(f) - int'(c);
        e.dout = d[8:0];
        e.low  = (d >= -2) && (d <= 2);
        e.col  = m_col[1:0];
        e.row  = m_row[1:0];
        e.fe   = (m_col == IMG_W - 1) && (m_row == IMG_H - 1);
        if (m_col == IMG_W - 1) begin
            m_col = 0;
            m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
        end else begin
            m_col = m_col + 1;
        end
        sb.push_back(e);
        last_exp = e;
    endtask

    // Drive one cycle of stimulus, update the model, then check level and sticky flags.
    task automatic apply(input logic fv, input logic [7:0] f, input logic cv,
                         input logic [7:0] c, input logic en);
        fine_valid   = fv;
        fine_in      = f;
        coarse_valid = cv;
        coarse_in    = c;
        Clk_en       = en;
        if (en) begin
            if (cv && m_fifo.size() == 0 && fv) begin
                make_pair(f, c);
            end else if (cv && m_fifo.size() > 0) begin
                make_pair(m_fifo.pop_front(), c);
                if (fv) m_fifo.push_back(f);
            end else if (cv) begin
                m_unf = 1'b1;
            end else if (fv) begin
                if (m_fifo.size() == FD) m_ovf = 1'b1;
                else m_fifo.push_back(f);
            end
        end
        @(posedge Clk);
        #1;
        chk("fifo_level", int'(fifo_level), m_fifo.size());
        chk("ovf_err", int'(ovf_err), int'(m_ovf));
        chk("unf_err", int'(unf_err), int'(m_unf));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dout"}, int'(dout), 0);
        chk({tag, "_dout_valid"}, int'(dout_valid), 0);
        chk({tag, "_col"}, int'(col), 0);
        chk({tag, "_row"}, int'(row), 0);
        chk({tag, "_frame_end"}, int'(frame_end), 0);
        chk({tag, "_low_contrast"}, int'(low_contrast), 0);
        chk({tag, "_fifo_level"}, int'(fifo_level), 0);
        chk({tag, "_ovf_err"}, int'(ovf_err), 0);
        chk({tag, "_unf_err"}, int'(unf_err), 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge Clk);
        #1;
        Reset        = 1'b1;
        fine_valid   = 1'b0;
        coarse_valid = 1'b0;
        Clk_en       = 1'b1;
        #1;
        check_all_zero(tag);
        m_fifo.delete();
        sb.delete();
        m_col    = 0;
        m_row    = 0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        last_exp = '0;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Scoreboard consumer: every presented output must match the oldest expectation.
    always @(negedge Clk) begin
        if (dout_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got dout_valid=1 dout=%0h, expected no output",
                         dout);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_dout", int'(dout), int'(e.dout));
                chk("sb_low_contrast", int'(low_contrast), int'(e.low));
                chk("sb_col", int'(col), int'(e.col));
                chk("sb_row", int'(row), int'(e.row));
                chk("sb_frame_end", int'(frame_end), int'(e.fe));
            end
        end else if (dout_valid !== 1'b0) begin
            chk("dout_valid_known", 1, 0);
        end
    end

    vec_t vecs[12];

    initial begin
        // Fine leads coarse by 5, then a bypass pair, then an idle cycle.
        for (int i = 0; i < 5; i++) vecs[i] = '{1'b1, 8'd200, 1'b0, 8'd0, i + 1, 1'b0, 9'd0, 1'b0};
        for (int i = 5; i < 10; i++)
            vecs[i] = '{1'b0, 8'd0, 1'b1, 8'd50, 9 - i, 1'b1, 9'd150, 1'b0};
        vecs[10] = '{1'b1, 8'd10, 1'b1, 8'd12, 0, 1'b1, 9'h1FE, 1'b1};
        vecs[11] = '{1'b0, 8'd0, 1'b0, 8'd0, 0, 1'b0, 9'd0, 1'b0};

        #1 Reset = 1'b1;
        #2 check_all_zero("reset");
        @(negedge Clk);
        Reset = 1'b0;

        // Table-driven: skew, latency and bypass.
        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].fv, vecs[i].f, vecs[i].cv, vecs[i].c, 1'b1);
            chk($sformatf("vec%0d_level", i), int'(fifo_level), vecs[i].exp_level);
            chk($sformatf("vec%0d_valid", i), int'(dout_valid), int'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_dout", i), int'(dout), int'(vecs[i].exp_dout));
                chk($sformatf("vec%0d_low", i), int'(low_contrast), int'(vecs[i].exp_low));
            end
        end

        // Full FIFO: simultaneous push/pop is legal, a lone push overflows and is dropped.
        for (int i = 0; i < 16; i++) apply(1'b1, 8'(i * 7 + 1), 1'b0, 8'd0, 1'b1);
        chk("full_level", int'(fifo_level), 16);
        apply(1'b1, 8'd99, 1'b1, 8'd0, 1'b1);
        chk("full_pushpop_level", int'(fifo_level), 16);
        chk("full_pushpop_ovf", int'(ovf_err), 0);
        apply(1'b1, 8'd200, 1'b0, 8'd0, 1'b1);
        chk("full_push_ovf", int'(ovf_err), 1);
        for (int i = 0; i < 16; i++) apply(1'b0, 8'd0, 1'b1, 8'd0, 1'b1);
        chk("drained_level", int'(fifo_level), 0);

        // Underflow: coarse with empty FIFO and no fine sample.
        apply(1'b0, 8'd0, 1'b1, 8'd5, 1'b1);
        chk("unf_set", int'(unf_err), 1);
        for (int i = 0; i < 3; i++) apply(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
        chk("unf_sticky", int'(unf_err), 1);

        // Full frame of 13 bypass pairs from (0,0).
        do_reset("rst_frame");
        for (int i = 0; i < 13; i++) begin
            apply(1'b1, 8'(i * 19), 1'b1, 8'(255 - i * 13), 1'b1);
            if (i == 11) begin
                chk("frame12_fe", int'(frame_end), 1);
                chk("frame12_col", int'(col), 3);
                chk("frame12_row", int'(row), 2);
            end
        end
        chk("frame13_fe", int'(frame_end), 0);
        chk("frame13_col", int'(col), 0);
        chk("frame13_row", int'(row), 0);

        // Mid-frame reset with 3 queued samples.
        do_reset("rst_pre");
        for (int i = 0; i < 9; i++) apply(1'b1, 8'(30 + i), 1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 6; i++) apply(1'b0, 8'd0, 1'b1, 8'd30, 1'b1);
        chk("pre_reset_level", int'(fifo_level), 3);
        do_reset("rst_mid");
        apply(1'b1, 8'd7, 1'b1, 8'd3, 1'b1);
        chk("post_reset_valid", int'(dout_valid), 1);
        chk("post_reset_dout", int'(dout), 4);
        chk("post_reset_col", int'(col), 0);
        chk("post_reset_row", int'(row), 0);

        // Clk_en low for 4 cycles: nothing moves, outputs hold.
        apply(1'b1, 8'd50, 1'b0, 8'd0, 1'b1);
        apply(1'b1, 8'd60, 1'b1, 8'd40, 1'b1);
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 8'd1, 1'b1, 8'd1, 1'b0);
            chk("stall_valid", int'(dout_valid), 0);
            chk("stall_fe", int'(frame_end), 0);
            chk("stall_dout", int'(dout), int'(last_exp.dout));
            chk("stall_col", int'(col), int'(last_exp.col));
            chk("stall_row", int'(row), int'(last_exp.row));
            chk("stall_low", int'(low_contrast), int'(last_exp.low));
        end
        apply(1'b0, 8'd0, 1'b1, 8'd20, 1'b1);
        chk("resume_col", int'(col), 2);
        chk("resume_dout", int'(dout), 40);
        apply(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
        apply(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
